// File: rtl/y86_pkg.sv
// Shared Y86-64 definitions: icode values, status codes and encoding helpers
// used by the prefetching fetch unit and its bus interface.
package y86_pkg;

  localparam logic [3:0] I_HALT   = 4'h0;
  localparam logic [3:0] I_NOP    = 4'h1;
  localparam logic [3:0] I_RRMOVQ = 4'h2;
  localparam logic [3:0] I_IRMOVQ = 4'h3;
  localparam logic [3:0] I_RMMOVQ = 4'h4;
  localparam logic [3:0] I_MRMOVQ = 4'h5;
  localparam logic [3:0] I_OPQ    = 4'h6;
  localparam logic [3:0] I_JXX    = 4'h7;
  localparam logic [3:0] I_CALL   = 4'h8;
  localparam logic [3:0] I_RET    = 4'h9;
  localparam logic [3:0] I_PUSHQ  = 4'hA;
  localparam logic [3:0] I_POPQ   = 4'hB;

  localparam logic [3:0] REG_NONE = 4'hF;

  typedef enum logic [1:0] {
    S_AOK = 2'd0,
    S_HLT = 2'd1,
    S_ADR = 2'd2,
    S_INS = 2'd3
  } stat_t;

  // Undefined icodes are one byte long so the fetch unit can report them.
  function automatic logic [3:0] ins_len(input logic [3:0] icode);
    case (icode)
      I_HALT, I_NOP, I_RET:               return 4'd1;
      I_RRMOVQ, I_OPQ, I_PUSHQ, I_POPQ:   return 4'd2;
      I_IRMOVQ, I_RMMOVQ, I_MRMOVQ:       return 4'd10;
      I_JXX, I_CALL:                      return 4'd9;
      default:                            return 4'd1;
    endcase
  endfunction

  function automatic logic has_regs(input logic [3:0] icode);
    return icode inside {I_RRMOVQ, I_IRMOVQ, I_RMMOVQ, I_MRMOVQ, I_OPQ, I_PUSHQ, I_POPQ};
  endfunction

  function automatic logic ifun_ok(input logic [3:0] icode, input logic [3:0] ifun);
    case (icode)
      I_RRMOVQ, I_JXX: return ifun <= 4'd6;
      I_OPQ:           return ifun <= 4'd3;
      default:         return ifun == 4'd0;
    endcase
  endfunction

endpackage

// File: rtl/y86_prefetch_fetch_if.sv
// Memory, redirect and instruction-output signals of the fetch unit.
// master = fetch unit, slave = surrounding memory system / pipeline.
interface y86_prefetch_fetch_if #(
  parameter int FETCH_BYTES = 8
);
  import y86_pkg::*;

  logic                     mem_req_valid;
  logic                     mem_req_ready;
  logic [63:0]              mem_req_addr;
  logic                     mem_rsp_valid;
  logic [8*FETCH_BYTES-1:0] mem_rsp_data;
  logic                     mem_rsp_err;
  logic                     redirect_valid;
  logic [63:0]              redirect_pc;
  logic                     ins_valid;
  logic                     ins_ready;
  logic [3:0]               icode, ifun, rA, rB;
  logic [63:0]              valC, valP, pc;
  stat_t                    stat;

  modport master (
    output mem_req_valid, mem_req_addr,
    input  mem_req_ready, mem_rsp_valid, mem_rsp_data, mem_rsp_err,
    input  redirect_valid, redirect_pc, ins_ready,
    output ins_valid, icode, ifun, rA, rB, valC, valP, pc, stat
  );

  modport slave (
    input  mem_req_valid, mem_req_addr,
    output mem_req_ready, mem_rsp_valid, mem_rsp_data, mem_rsp_err,
    output redirect_valid, redirect_pc, ins_ready,
    input  ins_valid, icode, ifun, rA, rB, valC, valP, pc, stat
  );

endinterface

// File: rtl/y86_byte_queue.sv
// Circular byte FIFO: pushes up to FETCH_BYTES bytes, pops up to 10,
// and exposes the 10 oldest bytes for decode.
module y86_byte_queue #(
  parameter  int FETCH_BYTES = 8,
  parameter  int QUEUE_DEPTH = 32,
  localparam int AW = $clog2(QUEUE_DEPTH),
  localparam int CW = AW + 1,
  localparam int NW = $clog2(FETCH_BYTES) + 1
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     flush,
  input  logic                     push,
  input  logic [NW-1:0]            push_cnt,
  input  logic [8*FETCH_BYTES-1:0] push_data,
  input  logic                     pop,
  input  logic [3:0]               pop_cnt,
  output logic [CW-1:0]            count,
  output logic [79:0]              peek
);

  logic [7:0]    store [QUEUE_DEPTH];
  logic [AW-1:0] rptr, wptr;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rptr  <= '0;
      wptr  <= '0;
      count <= '0;
    end else if (flush) begin
      rptr  <= '0;
      wptr  <= '0;
      count <= '0;
    end else begin
      if (push) wptr <= wptr + AW'(push_cnt);
      if (pop)  rptr <= rptr + AW'(pop_cnt);
      count <= count + (push ? CW'(push_cnt) : '0) - (pop ? CW'(pop_cnt) : '0);
    end
  end

  always_ff @(posedge clk) begin
    if (push && !flush) begin
      for (int i = 0; i < FETCH_BYTES; i++) begin
        if (i < int'(push_cnt)) store[wptr + AW'(i)] <= push_data[8*i +: 8];
      end
    end
  end

  always_comb begin
    peek = '0;
    for (int j = 0; j < 10; j++) peek[8*j +: 8] = store[rptr + AW'(j)];
  end

endmodule

// File: rtl/y86_prefetch_fetch.sv
// Y86-64 prefetching fetch unit: aligned block requests into a byte queue,
// decode at the queue head. Y86_FETCH_PREDICT_EN enables fetch redirection to jXX/call targets.
module y86_prefetch_fetch
  import y86_pkg::*;
#(
  parameter int          FETCH_BYTES = 8,
  parameter int          QUEUE_DEPTH = 32,
  parameter logic [63:0] RESET_PC    = 64'h0
) (
  input logic                  clk,
  input logic                  rst_n,
  y86_prefetch_fetch_if.master fif
);

  localparam int AW = $clog2(QUEUE_DEPTH);
  localparam int CW = AW + 1;
  localparam int OW = $clog2(FETCH_BYTES);
  localparam int NW = OW + 1;

  typedef enum logic {RUN, STOP} state_t;

  state_t        state;
  logic [63:0]   pc, fetch_addr;
  logic [1:0]    outstanding, stale;
  logic [OW-1:0] skip;
  logic          err, req_valid;

  logic [CW-1:0]            q_count;
  logic [79:0]              peek;
  logic                     q_push;
  logic [NW-1:0]            q_push_cnt;
  logic [8*FETCH_BYTES-1:0] q_push_data;

  logic [3:0]  d_icode, d_ifun, d_ra, d_rb, d_len;
  logic [63:0] d_valc, restart_pc;
  stat_t       d_stat, out_stat;
  logic        complete, adr_case, ins_valid, show, xfer, ok_xfer, take, restart;

  logic       fire, live_rsp, err_n, stop_n, space_ok, can_issue;
  logic [1:0] out_n, stale_n;

  y86_byte_queue #(.FETCH_BYTES(FETCH_BYTES), .QUEUE_DEPTH(QUEUE_DEPTH)) u_queue (
    .clk(clk), .rst_n(rst_n), .flush(restart),
    .push(q_push), .push_cnt(q_push_cnt), .push_data(q_push_data),
    .pop(xfer && !adr_case), .pop_cnt(d_len),
    .count(q_count), .peek(peek)
  );

  always_comb begin
    d_icode = peek[7:4];
    d_ifun  = peek[3:0];
    d_len   = ins_len(d_icode);
    d_ra    = has_regs(d_icode) ? peek[15:12] : REG_NONE;
    d_rb    = has_regs(d_icode) ? peek[11:8]  : REG_NONE;
    d_valc  = '0;
    if (d_icode inside {I_IRMOVQ, I_RMMOVQ, I_MRMOVQ}) d_valc = peek[79:16];
    else if (d_icode inside {I_JXX, I_CALL})           d_valc = peek[71:8];
    if (d_icode > I_POPQ || !ifun_ok(d_icode, d_ifun)) d_stat = S_INS;
    else if (d_icode == I_HALT)                        d_stat = S_HLT;
    else                                               d_stat = S_AOK;

    // After a memory error nothing more arrives, so an incomplete head is final.
    complete  = int'(q_count) >= int'(d_len);
    adr_case  = err && !complete;
    ins_valid = (state == RUN) && (complete || err);
    show      = ins_valid && !adr_case;
    out_stat  = adr_case ? S_ADR : d_stat;
    xfer      = ins_valid && fif.ins_ready;
    ok_xfer   = xfer && out_stat == S_AOK;
`ifdef Y86_FETCH_PREDICT_EN
    take = ok_xfer && (d_icode == I_JXX || d_icode == I_CALL);
`else
    take = 1'b0;
`endif
    restart    = fif.redirect_valid || take;
    restart_pc = fif.redirect_valid ? fif.redirect_pc : d_valc;
  end

  always_comb begin
    fire     = req_valid && fif.mem_req_ready;
    out_n    = outstanding + {1'b0, fire} - {1'b0, fif.mem_rsp_valid};
    stale_n  = (fif.mem_rsp_valid && stale != 2'd0) ? stale - 2'd1 : stale;
    live_rsp = fif.mem_rsp_valid && stale == 2'd0 && !err;
    err_n    = err || (live_rsp && fif.mem_rsp_err);
    q_push      = live_rsp && !fif.mem_rsp_err;
    q_push_data = fif.mem_rsp_data >> {skip, 3'b000};
    q_push_cnt  = NW'(FETCH_BYTES) - NW'(skip);
    stop_n   = (state == STOP) || (xfer && out_stat != S_AOK);
    // Reserve room for every live outstanding block and this cycle's push.
    space_ok = (QUEUE_DEPTH - int'(q_count) - int'(out_n - stale_n) * FETCH_BYTES
                - (q_push ? FETCH_BYTES : 0)) >= FETCH_BYTES;
    can_issue = !stop_n && !err_n && out_n < 2'd2 && space_ok;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= RUN;
      pc          <= RESET_PC;
      fetch_addr  <= {RESET_PC[63:OW], {OW{1'b0}}};
      skip        <= RESET_PC[OW-1:0];
      outstanding <= '0;
      stale       <= '0;
      err         <= 1'b0;
      req_valid   <= 1'b0;
    end else begin
      outstanding <= out_n;
      if (restart) begin
        state      <= RUN;
        pc         <= restart_pc;
        fetch_addr <= {restart_pc[63:OW], {OW{1'b0}}};
        skip       <= restart_pc[OW-1:0];
        stale      <= out_n;
        err        <= 1'b0;
        req_valid  <= 1'b0;
      end else begin
        stale <= stale_n;
        err   <= err_n;
        if (live_rsp) skip <= '0;
        if (fire) fetch_addr <= fetch_addr + 64'(FETCH_BYTES);
        if (xfer && out_stat != S_AOK) state <= STOP;
        if (ok_xfer) pc <= pc + 64'(d_len);
        req_valid <= (req_valid && !fif.mem_req_ready && !stop_n) || can_issue;
      end
    end
  end

  assign fif.mem_req_valid = req_valid;
  assign fif.mem_req_addr  = fetch_addr;
  assign fif.ins_valid     = ins_valid;
  assign fif.icode         = show ? d_icode : '0;
  assign fif.ifun          = show ? d_ifun  : '0;
  assign fif.rA            = show ? d_ra    : '0;
  assign fif.rB            = show ? d_rb    : '0;
  assign fif.valC          = show ? d_valc  : '0;
  assign fif.valP          = show ? pc + 64'(d_len) : '0;
  assign fif.pc            = pc;
  assign fif.stat          = ins_valid ? out_stat : S_AOK;

endmodule

// File: tb/tb_y86_prefetch_fetch.sv
// Directed bench for y86_prefetch_fetch with a byte-array memory model.
module tb_y86_prefetch_fetch;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  y86_prefetch_fetch_if #(.FETCH_BYTES(8)) fif ();

  y86_prefetch_fetch #(.FETCH_BYTES(8), .QUEUE_DEPTH(32), .RESET_PC(64'h0)) dut (
    .clk(clk), .rst_n(rst_n), .fif(fif)
  );

  typedef struct {
    logic [63:0] addr;
    int          due;
  } pend_t;

  logic [7:0]  mem [512];
  pend_t       pq [$];
  pend_t       cur;
  int          cyc;
  int          lat;
  logic [63:0] err_lo, err_hi;
  int          n_checks, n_errors;

  // Memory model: accept at the rising edge, answer on a falling edge.
  initial begin
    fif.mem_rsp_valid = 1'b0;
    fif.mem_rsp_err   = 1'b0;
    fif.mem_rsp_data  = '0;
    cyc = 0;
    forever begin
      @(posedge clk);
      if (!rst_n) pq.delete();
      else if (fif.mem_req_valid && fif.mem_req_ready) pq.push_back('{fif.mem_req_addr, cyc + lat});
      @(negedge clk);
      cyc++;
      fif.mem_rsp_valid = 1'b0;
      fif.mem_rsp_err   = 1'b0;
      if (rst_n && pq.size() > 0 && pq[0].due <= cyc) begin
        cur = pq.pop_front();
        fif.mem_rsp_valid = 1'b1;
        fif.mem_rsp_err   = (cur.addr >= err_lo) && (cur.addr < err_hi);
        for (int i = 0; i < 8; i++) fif.mem_rsp_data[8*i +: 8] = mem[9'(cur.addr + 64'(i))];
      end
    end
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic clear_mem();
    for (int i = 0; i < 512; i++) mem[i] = 8'h00;
    err_lo = 64'hFFFF_FFFF_FFFF_FFFF;
    err_hi = 64'h0;
    lat    = 1;
  endtask

  task automatic load(input int addr, input int n, input logic [127:0] bytes);
    for (int i = 0; i < n; i++) mem[9'(addr + i)] = bytes[8*(n-1-i) +: 8];
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    fif.redirect_valid = 1'b0;
    fif.redirect_pc    = '0;
    fif.ins_ready      = 1'b0;
    fif.mem_req_ready  = 1'b1;
    repeat (3) @(negedge clk);
    check("rst ins_valid", fif.ins_valid, 0);
    check("rst mem_req_valid", fif.mem_req_valid, 0);
    check("rst pc", fif.pc, 64'h0);
    check("rst stat", fif.stat, 0);
    check("rst icode", fif.icode, 0);
    check("rst valP", fif.valP, 0);
    rst_n = 1'b1;
  endtask

  task automatic wait_ins(input string tag);
    int k = 0;
    while (!fif.ins_valid && k < 300) begin
      @(negedge clk);
      k++;
    end
    check({tag, " ins_valid"}, fif.ins_valid, 1);
  endtask

  task automatic take_ins();
    fif.ins_ready = 1'b1;
    @(negedge clk);
    fif.ins_ready = 1'b0;
  endtask

  task automatic expect_ins(input string tag, input logic [3:0] ic, input logic [3:0] fn,
                            input logic [3:0] ra, input logic [3:0] rb, input logic [63:0] vc,
                            input logic [63:0] vp, input logic [63:0] p, input logic [1:0] st);
    wait_ins(tag);
    check({tag, " icode"}, fif.icode, ic);
    check({tag, " ifun"},  fif.ifun,  fn);
    check({tag, " rA"},    fif.rA,    ra);
    check({tag, " rB"},    fif.rB,    rb);
    check({tag, " valC"},  fif.valC,  vc);
    check({tag, " valP"},  fif.valP,  vp);
    check({tag, " pc"},    fif.pc,    p);
    check({tag, " stat"},  fif.stat,  st);
    take_ins();
  endtask

  task automatic expect_quiet(input string tag);
    int v = 0;
    int r = 0;
    repeat (8) begin
      @(negedge clk);
      if (fif.ins_valid) v++;
      if (fif.mem_req_valid) r++;
    end
    check({tag, " ins_valid cycles"}, v, 0);
    check({tag, " mem_req_valid cycles"}, r, 0);
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    rst_n = 1'b0;

    // irmovq $10,%rdx ; halt
    clear_mem();
    load(0, 10, 80'h30F20A00000000000000);
    do_reset();
    expect_ins("irmovq", 4'h3, 4'h0, 4'hF, 4'h2, 64'hA, 64'hA, 64'h0, 2'd0);
    expect_ins("halt", 4'h0, 4'h0, 4'hF, 4'hF, 64'h0, 64'hB, 64'hA, 2'd1);
    expect_quiet("after halt");

    // nop ; addq %rdx,%rbx with back-pressure
    clear_mem();
    load(0, 3, 24'h106023);
    do_reset();
    wait_ins("nop hold");
    repeat (5) begin
      @(negedge clk);
      check("hold ins_valid", fif.ins_valid, 1);
      check("hold icode", fif.icode, 4'h1);
      check("hold pc", fif.pc, 64'h0);
    end
    expect_ins("nop", 4'h1, 4'h0, 4'hF, 4'hF, 64'h0, 64'h1, 64'h0, 2'd0);
    expect_ins("addq", 4'h6, 4'h0, 4'h2, 4'h3, 64'h0, 64'h3, 64'h1, 2'd0);

    // Illegal icode stops fetch; redirect restarts it
    clear_mem();
    load(0, 1, 8'hC0);
    load(64'h40, 2, 16'h2013);
    do_reset();
    wait_ins("illegal");
    check("illegal stat", fif.stat, 2'd3);
    check("illegal pc", fif.pc, 64'h0);
    take_ins();
    expect_quiet("stopped");
    fif.redirect_valid = 1'b1;
    fif.redirect_pc    = 64'h40;
    @(negedge clk);
    fif.redirect_valid = 1'b0;
    expect_ins("rrmovq", 4'h2, 4'h0, 4'h1, 4'h3, 64'h0, 64'h42, 64'h40, 2'd0);

    // irmovq straddling an erroring block
    clear_mem();
    load(0, 10, 80'h30F30000000000000000);
    err_lo = 64'h8;
    err_hi = 64'h10;
    do_reset();
    wait_ins("adr");
    check("adr stat", fif.stat, 2'd2);
    check("adr pc", fif.pc, 64'h0);
    take_ins();
    expect_quiet("after adr");

    // Redirect with two requests in flight; stale nops must be dropped
    clear_mem();
    for (int i = 0; i < 256; i++) mem[i] = 8'h10;
    load(64'h103, 2, 16'h6045);
    lat = 6;
    do_reset();
    repeat (3) @(negedge clk);
    fif.redirect_valid = 1'b1;
    fif.redirect_pc    = 64'h103;
    @(negedge clk);
    fif.redirect_valid = 1'b0;
    check("redirect ins_valid low", fif.ins_valid, 0);
    expect_ins("redir addq", 4'h6, 4'h0, 4'h4, 4'h5, 64'h0, 64'h105, 64'h103, 2'd0);

    // jmp 0x80 with a nop after it and halt at the target
    clear_mem();
    load(0, 9, 72'h708000000000000000);
    mem[9]    = 8'h10;
    mem[9'h80] = 8'h00;
    do_reset();
    expect_ins("jmp", 4'h7, 4'h0, 4'hF, 4'hF, 64'h80, 64'h9, 64'h0, 2'd0);
    wait_ins("after jmp");
`ifdef Y86_FETCH_PREDICT_EN
    check("after jmp pc", fif.pc, 64'h80);
    check("after jmp icode", fif.icode, 4'h0);
    check("after jmp stat", fif.stat, 2'd1);
`else
    check("after jmp pc", fif.pc, 64'h9);
    check("after jmp icode", fif.icode, 4'h1);
    check("after jmp stat", fif.stat, 2'd0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, checks %0d", n_checks);
    $fatal(1);
  end

endmodule
